// File: rtl/hr_4t16_demux_align.sv
// Receive-side 4:16 deserializer: hunts for a repeated training word, confirms it on
// word boundaries, then emits one bit/word-aligned 16-bit word every 4 nibble cycles.
module hr_4t16_demux_align #(
  parameter logic [15:0] SYNC_WORD = 16'hF628,
  parameter int unsigned LOCK_CNT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  din,
  input  logic        relock,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        locked,
  output logic [1:0]  bit_off,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT_L = 4'(LOCK_CNT);

  state_t      state, state_nxt;
  logic [19:0] h;
  logic [1:0]  ph, ph_nxt;
  logic [3:0]  mcnt, mcnt_nxt;
  logic [15:0] dout_nxt;
  logic        dout_valid_nxt;
  logic [1:0]  bit_off_nxt;

  logic [15:0] win [4];
  logic [3:0]  hit;
  logic [1:0]  low_hit;
  logic [15:0] win_sel;
  logic        boundary;

  // Four candidate windows, one per bit offset, taken from the registered history.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      win[b] = h[b +: 16];
      hit[b] = (win[b] == SYNC_WORD);
    end
  end

  always_comb begin
    low_hit = 2'd0;
    if (hit[0])      low_hit = 2'd0;
    else if (hit[1]) low_hit = 2'd1;
    else if (hit[2]) low_hit = 2'd2;
    else if (hit[3]) low_hit = 2'd3;
  end

  assign win_sel   = win[bit_off];
  assign boundary  = (ph == 2'd3);
  assign state_dbg = state;

  always_comb begin
    state_nxt      = state;
    ph_nxt         = ph + 2'd1;
    mcnt_nxt       = mcnt;
    bit_off_nxt    = bit_off;
    dout_nxt       = dout;
    dout_valid_nxt = 1'b0;
    if (relock) begin
      state_nxt = HUNT;
      mcnt_nxt  = '0;
    end else begin
      case (state)
        HUNT: begin
          // Restarting the phase here puts the next boundary exactly one word later.
          if (|hit) begin
            bit_off_nxt = low_hit;
            ph_nxt      = 2'd0;
            mcnt_nxt    = 4'd1;
            state_nxt   = CHECK;
          end
        end
        CHECK: begin
          if (boundary) begin
            if (win_sel == SYNC_WORD) begin
              mcnt_nxt = mcnt + 4'd1;
              if (mcnt + 4'd1 == LOCK_CNT_L) state_nxt = LOCKED;
            end else begin
              mcnt_nxt  = '0;
              state_nxt = HUNT;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            dout_nxt       = win_sel;
            dout_valid_nxt = 1'b1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      h          <= '0;
      ph         <= '0;
      mcnt       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      locked     <= 1'b0;
      bit_off    <= '0;
    end else begin
      state      <= state_nxt;
      h          <= {din, h[19:4]};
      ph         <= ph_nxt;
      mcnt       <= mcnt_nxt;
      dout       <= dout_nxt;
      dout_valid <= dout_valid_nxt;
      locked     <= (state_nxt == LOCKED);
      bit_off    <= bit_off_nxt;
    end
  end

endmodule

// File: doc/hr_4t16_demux_align.md
# hr_4t16_demux_align

Receive-side counterpart of the half-rate 16:4 serializer. Accepts a 4-bit parallel lane stream, one nibble per `clk` cycle, and rebuilds 16-bit words. Word and bit alignment come from a training sync word that the transmitter repeats. After lock it emits one aligned 16-bit word every 4 cycles with a valid strobe to the digital receive datapath.

## Interface
- `SYNC_WORD`, default 16'hF628: training word the transmitter repeats back-to-back until lock.
- `LOCK_CNT`, default 4, range 2..15: consecutive sync matches required to declare lock, counting the first match.
- `clk`  input  1: nibble-rate clock; all state updates on its rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `din`  input  4: received lane nibble. `din[0]` is the earliest-transmitted bit.
- `relock`  input  1: synchronous; forces a return to HUNT.
- `dout`  output  16: aligned word. `dout[0]` is the earliest bit.
- `dout_valid`  output  1: one-cycle strobe marking a new `dout`.
- `locked`  output  1: high in LOCKED state.
- `bit_off`  output  2: bit offset selected at alignment.

## Operation
- History register `h[19:0]`:
  - Every cycle `h <= {din, h[19:4]}`; newest nibble enters at the top.
  - Candidate window for bit offset b is `W(b) = h[b+15:b]`, for b = 0..3.
- Phase counter `ph[1:0]` increments every cycle and wraps 3 -> 0. A word boundary is the cycle where `ph == 3`.
- State machine, with states HUNT, CHECK and LOCKED:
  - **HUNT:**
    - Compare `W(0..3)` with `SYNC_WORD` every cycle.
    - On any match: latch the lowest matching b into `bit_off`, load `ph <= 0`, load the match counter `mcnt <= 1`, and go to CHECK. This makes the next boundary exactly 4 cycles later.
  - **CHECK:**
    - At each boundary compare `W(bit_off)` with `SYNC_WORD`.
    - On match, `mcnt++`. If `mcnt` reaches `LOCK_CNT`, go to LOCKED.
    - On mismatch, go to HUNT and clear `mcnt`.
    - No comparison is made off-boundary.
  - **LOCKED:**
    - At each boundary, `dout <= W(bit_off)` and `dout_valid <= 1`.
    - No sync checking; payload is unconstrained.
    - Stay in LOCKED until `relock` or reset.
- `relock` high in any state:
  - Next state is HUNT, with `mcnt`, `dout_valid` and `locked` cleared.
  - `dout` and `bit_off` hold their values.
  - `relock` takes priority over a simultaneous match.
- No output words are produced in HUNT or CHECK.
- Bit offset and phase are fixed from the initial HUNT match; they are re-acquired only via HUNT.

## Timing
- Reset values, asynchronous on `rst_n` low:
  - `h`, `dout`, `bit_off`, `ph` and `mcnt` are 0.
  - `dout_valid` = 0, `locked` = 0, state = HUNT.
- Release of `rst_n` is used synchronously.
- Compare logic is combinational on registered `h`. State, counters and outputs are registered.
- Latency: nibble containing a word's last bit sampled at edge N -> matching `dout`/`dout_valid` at edge N+1, when `ph == 3` at edge N.
- `dout_valid` is high for exactly 1 cycle per 4 in LOCKED.
- `locked` rises on the edge that makes the `LOCK_CNT`-th match. The first `dout_valid` follows 4 cycles later.
- `locked` drops on the edge following `relock`; any `dout_valid` strobe due that cycle is suppressed.
- With `LOCK_CNT` = 4 and a continuous sync stream, `locked` is set 12 cycles after the first HUNT match.

## Test plan
- **Reset:**
  - Stimulus: assert `rst_n` = 0 mid-stream while LOCKED, including between edges.
  - Required: `dout` = 0, `dout_valid` = 0, `locked` = 0 and `bit_off` = 0 immediately; state HUNT on release.
- **Aligned lock, b = 0:**
  - Stimulus: 8 back-to-back 16'hF628 words, then payload 16'h1234, 16'hABCD.
  - Required:
    - `bit_off` = 0.
    - `locked` high 12 cycles after the first match.
    - `dout` = 16'h1234 then 16'hABCD, each with a single `dout_valid` pulse 4 cycles apart.
- **Bit offset:**
  - Stimulus: the same stream delayed by 2 bit times (2 filler bits of 0).
  - Required: `bit_off` = 2, and the payload is recovered exactly as 16'h1234, 16'hABCD.
- **CHECK failure:**
  - Stimulus: sync, sync, 16'h0000, then sync words again.
  - Required: return to HUNT after the third word with `locked` never asserted; relock follows on the later syncs.
- **Relock:**
  - Stimulus: pulse `relock` while LOCKED at a `ph == 3` cycle, with a different bit offset (1) on the subsequent sync stream.
  - Required: that cycle's `dout_valid` is suppressed, `locked` falls next edge, and the block relocks with `bit_off` = 1.
- **Multiple matches:**
  - Stimulus: `SYNC_WORD` = 16'hFFFF with all-ones input.
  - Required: HUNT picks `bit_off` = 0 (lowest matching offset).
